// File: rtl/mac_feeder_4x4_pkg.sv
// Shared widths and FSM encoding for the 4x4 MAC array feeder.
package mac_feeder_4x4_pkg;

    localparam int DW      = 8;
    localparam int KW      = 8;
    localparam int N_LANES = 4;
    localparam int DRAIN   = 3 * N_LANES - 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN_ST = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mac_feeder_4x4_skew_chain.sv
// DEPTH-stage shift register cleared to zero on reset; one per skewed lane.
module skew_chain #(
    parameter int DW    = 8,
    parameter int DEPTH = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DEPTH-1:0][DW-1:0] stage;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/mac_feeder_4x4.sv
// Job sequencer and diagonal skew for a 4x4 systolic MAC array:
// clear accumulators, feed k_len beats, drain the array, pulse done.
module mac_feeder_4x4 #(
    parameter int DW    = mac_feeder_4x4_pkg::DW,
    parameter int KW    = mac_feeder_4x4_pkg::KW,
    parameter int DRAIN = mac_feeder_4x4_pkg::DRAIN
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] k_len,
    input  logic [4*DW-1:0] a_vec,
    input  logic [4*DW-1:0] w_vec,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] ain1,
    output logic [DW-1:0] ain2,
    output logic [DW-1:0] ain3,
    output logic [DW-1:0] ain4,
    output logic [DW-1:0] win1,
    output logic [DW-1:0] win2,
    output logic [DW-1:0] win3,
    output logic [DW-1:0] win4,
    output logic          acc_clr,
    output logic          busy,
    output logic          done
);
    import mac_feeder_4x4_pkg::*;

    localparam int DCW = $clog2(DRAIN + 1);

    state_t         state, state_nxt;
    logic [KW-1:0]  k_lat, beat_cnt;
    logic [DCW-1:0] drain_cnt;
    logic           accept, last_beat, drain_end;

    logic [N_LANES-1:0][DW-1:0] a_in, w_in, a_out, w_out;

    assign accept    = in_valid && in_ready;
    // k_lat is never zero in FEED, so the minus-one cannot underflow there.
    assign last_beat = (beat_cnt == k_lat - KW'(1));
    assign drain_end = (drain_cnt == DCW'(DRAIN - 1));

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        acc_clr   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = CLEAR;
            end
            CLEAR: begin
                acc_clr   = 1'b1;
                state_nxt = (k_lat == '0) ? DONE : FEED;
            end
            FEED: begin
                in_ready = 1'b1;
                if (accept && last_beat) state_nxt = DRAIN_ST;
            end
            DRAIN_ST: begin
                if (drain_end) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k_lat     <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) k_lat <= k_len;

            if (state == CLEAR)  beat_cnt <= '0;
            else if (accept)     beat_cnt <= beat_cnt + KW'(1);

            if (state == DRAIN_ST) drain_cnt <= drain_cnt + DCW'(1);
            else                   drain_cnt <= '0;
        end
    end

    // Non-accepted cycles inject zero beats so products add nothing.
    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        assign a_in[g] = accept ? a_vec[g*DW +: DW] : '0;
        assign w_in[g] = accept ? w_vec[g*DW +: DW] : '0;

        skew_chain #(.DW(DW), .DEPTH(g + 1)) u_act (
            .clk (clk),
            .rst (rst),
            .din (a_in[g]),
            .dout(a_out[g])
        );

        skew_chain #(.DW(DW), .DEPTH(g + 1)) u_wt (
            .clk (clk),
            .rst (rst),
            .din (w_in[g]),
            .dout(w_out[g])
        );
    end

    assign ain1 = a_out[0];
    assign ain2 = a_out[1];
    assign ain3 = a_out[2];
    assign ain4 = a_out[3];
    assign win1 = w_out[0];
    assign win2 = w_out[1];
    assign win3 = w_out[2];
    assign win4 = w_out[3];

endmodule

// File: tb/tb_mac_feeder_4x4.sv
// Directed bench for mac_feeder_4x4 with a behavioural 4x4 systolic array on its outputs.
module tb_mac_feeder_4x4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  k_len;
    logic [31:0] a_vec, w_vec;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  ain1, ain2, ain3, ain4, win1, win2, win3, win4;
    logic        acc_clr, busy, done;

    int errors = 0;
    int checks = 0;

    mac_feeder_4x4 dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .a_vec(a_vec), .w_vec(w_vec), .in_valid(in_valid), .in_ready(in_ready),
        .ain1(ain1), .ain2(ain2), .ain3(ain3), .ain4(ain4),
        .win1(win1), .win2(win2), .win3(win3), .win4(win4),
        .acc_clr(acc_clr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Systolic array: a flows right along rows, w flows down columns.
    logic [7:0]  arow[4], wcol[4];
    logic [7:0]  ai[4][4], wi[4][4], ah[4][4], wv[4][4];
    logic [31:0] acc[4][4];

    assign arow[0] = ain1; assign arow[1] = ain2; assign arow[2] = ain3; assign arow[3] = ain4;
    assign wcol[0] = win1; assign wcol[1] = win2; assign wcol[2] = win3; assign wcol[3] = win4;

    for (genvar gi = 0; gi < 4; gi++) begin : g_r
        for (genvar gj = 0; gj < 4; gj++) begin : g_c
            if (gj == 0) begin : g_ae
                assign ai[gi][gj] = arow[gi];
            end else begin : g_ai
                assign ai[gi][gj] = ah[gi][gj-1];
            end
            if (gi == 0) begin : g_we
                assign wi[gi][gj] = wcol[gj];
            end else begin : g_wi
                assign wi[gi][gj] = wv[gi-1][gj];
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (rst || acc_clr) begin
                    acc[i][j] <= '0;
                    ah[i][j]  <= '0;
                    wv[i][j]  <= '0;
                end else begin
                    acc[i][j] <= acc[i][j] + 32'(ai[i][j]) * 32'(wi[i][j]);
                    ah[i][j]  <= ai[i][j];
                    wv[i][j]  <= wi[i][j];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
    endtask

    task automatic begin_job(input logic [7:0] k);
        start = 1'b1;
        k_len = k;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, in_ready, acc_clr, done} !== 4'b0 ||
            {ain1, ain2, ain3, ain4, win1, win2, win3, win4} !== 64'h0) begin
            errors++;
            $display("FAIL reset_init: busy=%b rdy=%b clr=%b done=%b", busy, in_ready, acc_clr, done);
        end
        begin_job(8'd5);
        tick();
        in_valid = 1'b1;
        a_vec = 32'h11223344;
        w_vec = 32'h55667788;
        tick();
        tick();
        checks++;
        if (ain1 !== 8'h44 || win1 !== 8'h88) begin
            errors++;
            $display("FAIL reset_prefeed: ain1=%h win1=%h want 44 88", ain1, win1);
        end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({busy, in_ready, acc_clr, done} !== 4'b0 ||
                {ain1, ain2, ain3, ain4, win1, win2, win3, win4} !== 64'h0) begin
                errors++;
                $display("FAIL reset_mid_feed c%0d: busy=%b rdy=%b done=%b ain=%h%h%h%h",
                         c, busy, in_ready, done, ain1, ain2, ain3, ain4);
            end
        end
        rst = 1'b0;
        in_valid = 1'b0;
        begin
            int seen = 0;
            for (int c = 0; c < 14; c++) begin
                tick();
                if (done === 1'b1 || busy === 1'b1) seen++;
            end
            checks++;
            if (seen != 0) begin
                errors++;
                $display("FAIL reset_no_done: busy/done cycles=%0d want 0", seen);
            end
        end
    endtask

    task automatic test_single_beat();
        int n;
        begin_job(8'd1);
        checks++;
        if (acc_clr !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_clear: clr=%b busy=%b rdy=%b want 1 1 0", acc_clr, busy, in_ready);
        end
        a_vec = 32'h04030201;
        w_vec = 32'h08070605;
        in_valid = 1'b1;
        tick();
        checks++;
        if (acc_clr !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_feed: clr=%b rdy=%b want 0 1", acc_clr, in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (ain1 !== 8'h01 || win1 !== 8'h05 || ain2 !== 8'h00 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_lane0: ain1=%h win1=%h ain2=%h rdy=%b want 01 05 00 0",
                     ain1, win1, ain2, in_ready);
        end
        tick();
        checks++;
        if (ain2 !== 8'h02 || win2 !== 8'h06 || ain1 !== 8'h00) begin
            errors++;
            $display("FAIL single_lane1: ain2=%h win2=%h ain1=%h want 02 06 00", ain2, win2, ain1);
        end
        tick();
        checks++;
        if (ain3 !== 8'h03 || win3 !== 8'h07) begin
            errors++;
            $display("FAIL single_lane2: ain3=%h win3=%h want 03 07", ain3, win3);
        end
        tick();
        checks++;
        if (ain4 !== 8'h04 || win4 !== 8'h08 || ain3 !== 8'h00) begin
            errors++;
            $display("FAIL single_lane3: ain4=%h win4=%h ain3=%h want 04 08 00", ain4, win4, ain3);
        end
        wait_done(n);
        checks++;
        if (done !== 1'b1 || n + 3 != 10) begin
            errors++;
            $display("FAIL single_done_latency: done=%b cycles=%0d want 1 10", done, n + 3);
        end
        checks++;
        if (acc[0][0] !== 32'd5 || acc[3][3] !== 32'd32 || acc[0][3] !== 32'd8) begin
            errors++;
            $display("FAIL single_array: s11=%0d s44=%0d s14=%0d want 5 32 8",
                     acc[0][0], acc[3][3], acc[0][3]);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_bubbles();
        logic [6:0] pat;
        int sum, n, bad_ain;
        pat = 7'b1010101;
        sum = 0;
        bad_ain = 0;
        begin_job(8'd4);
        tick();
        for (int c = 0; c < 7; c++) begin
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL bubble_ready c%0d: rdy=%b want 1", c, in_ready);
            end
            in_valid = pat[c];
            a_vec = {24'h0, 8'(c + 1)};
            w_vec = {24'h0, 8'(c + 2)};
            tick();
            if (ain1 !== (pat[c] ? 8'(c + 1) : 8'h00)) bad_ain++;
            sum += int'(ain1) * int'(win1);
        end
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || bad_ain != 0) begin
            errors++;
            $display("FAIL bubble_count: rdy=%b bad_ain=%0d want 0 0", in_ready, bad_ain);
        end
        checks++;
        if (sum != 100) begin
            errors++;
            $display("FAIL bubble_dot: got %0d want 100", sum);
        end
        wait_done(n);
        checks++;
        if (done !== 1'b1 || acc[0][0] !== 32'd100) begin
            errors++;
            $display("FAIL bubble_sout11: done=%b s11=%0d want 1 100", done, acc[0][0]);
        end
        tick();
    endtask

    task automatic test_zero_len();
        begin_job(8'd0);
        checks++;
        if (acc_clr !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_clear: clr=%b rdy=%b want 1 0", acc_clr, in_ready);
        end
        tick();
        checks++;
        if (done !== 1'b1 || acc_clr !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: done=%b clr=%b rdy=%b want 1 0 0", done, acc_clr, in_ready);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_ignore_start();
        int n;
        begin_job(8'd3);
        tick();
        in_valid = 1'b1;
        a_vec = 32'h000000A1;
        start = 1'b1;
        k_len = 8'd1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ignore_klen: rdy=%b want 1 after beat 1 of 3", in_ready);
        end
        start = 1'b0;
        a_vec = 32'h000000A2;
        tick();
        checks++;
        if (in_ready !== 1'b1 || ain1 !== 8'hA2) begin
            errors++;
            $display("FAIL ignore_beat2: rdy=%b ain1=%h want 1 a2", in_ready, ain1);
        end
        a_vec = 32'h000000A3;
        tick();
        checks++;
        if (in_ready !== 1'b0 || ain1 !== 8'hA3) begin
            errors++;
            $display("FAIL ignore_beat3: rdy=%b ain1=%h want 0 a3", in_ready, ain1);
        end
        a_vec = 32'h000000A4;
        start = 1'b1;
        tick();
        checks++;
        if (ain1 !== 8'h00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drain_valid: ain1=%h busy=%b want 00 1", ain1, busy);
        end
        start = 1'b0;
        in_valid = 1'b0;
        wait_done(n);
        checks++;
        if (done !== 1'b1 || n != 9) begin
            errors++;
            $display("FAIL ignore_done: done=%b cycles=%0d want 1 9", done, n);
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_restart: busy=%b want 0", busy);
        end
    endtask

    task automatic test_max_len();
        int early, n;
        early = 0;
        begin_job(8'd255);
        tick();
        a_vec = 32'h01010101;
        w_vec = 32'h01010101;
        in_valid = 1'b1;
        for (int b = 0; b < 255; b++) begin
            if (in_ready !== 1'b1) early++;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (early != 0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL max_len: early_drops=%0d rdy=%b want 0 0", early, in_ready);
        end
        wait_done(n);
        checks++;
        if (done !== 1'b1 || acc[0][0] !== 32'd255 || acc[3][3] !== 32'd255) begin
            errors++;
            $display("FAIL max_len_sum: done=%b s11=%0d s44=%0d want 1 255 255",
                     done, acc[0][0], acc[3][3]);
        end
        tick();
    endtask

    task automatic run_full_job(input int seed);
        logic [7:0] a[16][4], w[16][4];
        int gold, n;
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 4; i++) begin
                a[k][i] = 8'((k * 4 + i) * 37 + seed * 11 + 5);
                w[k][i] = 8'((k * 5 + i) * 23 + seed * 7 + 9);
            end
        end
        begin_job(8'd16);
        tick();
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 4; i++) begin
                a_vec[i*8 +: 8] = a[k][i];
                w_vec[i*8 +: 8] = w[k][i];
            end
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        wait_done(n);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL full_done seed%0d: no done within bound", seed);
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                gold = 0;
                for (int k = 0; k < 16; k++) gold += int'(a[k][i]) * int'(w[k][j]);
                checks++;
                if (acc[i][j] !== 32'(gold)) begin
                    errors++;
                    $display("FAIL full_sout%0d%0d seed%0d: got %0d want %0d",
                             i + 1, j + 1, seed, acc[i][j], gold);
                end
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        run_full_job(1);
        run_full_job(2);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        k_len = '0;
        a_vec = '0;
        w_vec = '0;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_single_beat();
        test_bubbles();
        test_zero_len();
        test_ignore_start();
        test_max_len();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
